com_controller: RTL

COM_CONTROLLER -- requirements
Module: com_controller

---
 rtl/com_controller_pkg.sv | 16 +
 rtl/com_controller_dump_seq.sv | 64 ++++++
 rtl/com_controller.sv | 114 +++++++++++
 3 files changed

// File: rtl/com_controller_pkg.sv
// Shared definitions for the host/core communication controller:
// simulation clock period, default widths and the FSM state encoding.
package com_controller_pkg;

  localparam int CLOCK          = 10;
  localparam int DEFAULT_DATA_W = 16;
  localparam int DEFAULT_ADDR_W = 12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_RUN  = 2'b10,
    ST_DUMP = 2'b11
  } com_state_t;

endpackage

// File: rtl/com_controller_dump_seq.sv
// Dump sequencer: steps the read address over the dump window and carries
// valid/last through the memory-latency stage and the output register.
module com_dump_seq #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 12,
  parameter int DUMP_BASE = 0,
  parameter int DUMP_LEN  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] rd_data,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              out_last
);

  localparam int CNT_W = $clog2(DUMP_LEN + 1);

  logic [CNT_W-1:0] remaining;
  logic             rd_last;
  logic             stage_valid;
  logic             stage_last;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_en       <= 1'b0;
      rd_addr     <= '0;
      remaining   <= '0;
      rd_last     <= 1'b0;
      stage_valid <= 1'b0;
      stage_last  <= 1'b0;
      out_data    <= '0;
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
    end else begin
      if (start) begin
        rd_en     <= 1'b1;
        rd_addr   <= ADDR_W'(DUMP_BASE);
        remaining <= CNT_W'(DUMP_LEN - 1);
        rd_last   <= (DUMP_LEN == 1);
      end else if (rd_en) begin
        if (remaining == '0) begin
          rd_en   <= 1'b0;
          rd_last <= 1'b0;
        end else begin
          // Address wraps naturally modulo 2^ADDR_W.
          rd_addr   <= rd_addr + 1'b1;
          remaining <= remaining - 1'b1;
          rd_last   <= (remaining == CNT_W'(1));
        end
      end

      stage_valid <= rd_en;
      stage_last  <= rd_en & rd_last;
      out_valid   <= stage_valid;
      out_last    <= stage_last;
      out_data    <= stage_valid ? rd_data : '0;
    end
  end

endmodule

// File: rtl/com_controller.sv
// Communication controller: loads host words into data memory, kicks the
// cores, waits for completion and streams a memory window back to the host.
module com_controller
  import com_controller_pkg::*;
#(
  parameter int DATA_W    = DEFAULT_DATA_W,
  parameter int ADDR_W    = DEFAULT_ADDR_W,
  parameter int DUMP_BASE = 0,
  parameter int DUMP_LEN  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] com_data_in,
  input  logic              data_write_start,
  input  logic              data_write_done,
  input  logic              proc_done,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  output logic              mem_wr_en,
  output logic              mem_rd_en,
  output logic              proc_start,
  output logic [1:0]        state,
  output logic [DATA_W-1:0] com_data_out,
  output logic              output_write_start,
  output logic              output_write_done
);

  com_state_t        state_q;
  logic [ADDR_W-1:0] load_cnt;
  logic              load_full;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;
  logic              proc_start_q;

  logic              dump_start;
  logic              dump_rd_en;
  logic [ADDR_W-1:0] dump_addr;
  logic              dump_last;

  assign dump_start = (state_q == ST_RUN) && proc_done;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      load_cnt     <= '0;
      load_full    <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      proc_start_q <= 1'b0;
    end else begin
      wr_en_q      <= 1'b0;
      proc_start_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (data_write_start) begin
            state_q   <= ST_LOAD;
            load_cnt  <= '0;
            load_full <= 1'b0;
          end
        end
        ST_LOAD: begin
          // Once the top address has been written, further words are dropped.
          if (!load_full) begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= load_cnt;
            wr_data_q <= com_data_in;
            if (load_cnt == '1) load_full <= 1'b1;
            else                load_cnt  <= load_cnt + 1'b1;
          end
          if (data_write_done || !data_write_start) begin
            state_q      <= ST_RUN;
            proc_start_q <= 1'b1;
          end
        end
        ST_RUN: begin
          if (proc_done) state_q <= ST_DUMP;
        end
        ST_DUMP: begin
          if (dump_last) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  com_dump_seq #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .DUMP_BASE (DUMP_BASE),
    .DUMP_LEN  (DUMP_LEN)
  ) u_dump_seq (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (dump_start),
    .rd_data   (mem_rd_data),
    .rd_en     (dump_rd_en),
    .rd_addr   (dump_addr),
    .out_data  (com_data_out),
    .out_valid (output_write_start),
    .out_last  (dump_last)
  );

  assign mem_addr          = dump_rd_en ? dump_addr : wr_addr_q;
  assign mem_wr_data       = wr_data_q;
  assign mem_wr_en         = wr_en_q;
  assign mem_rd_en         = dump_rd_en;
  assign proc_start        = proc_start_q;
  assign state             = state_q;
  assign output_write_done = dump_last;

endmodule
